matmul_job_sender: RTL and testbench

- Host-side/driver end of the matrix-multiplier byte protocol: serializes one job onto a byte-wide UART transmit interface and collects the returned result bytes from the receive interface.
  - Job = header, then cached rows, then columns.
- Used for on-chip loopback/self-test and for chaining a second multiplier.
- Payload bytes arrive from a local streaming source. Results leave on a pulse interface tagged with row/column indices.

---
 rtl/matmul_proto_pkg.sv | 56 +++++
 rtl/uart_byte_tx_hs.sv | 71 +++++++
 rtl/matmul_job_sender.sv | 218 +++++++++++++++++++++
 tb/tb_matmul_job_sender.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_proto_pkg.sv
`default_nettype none
// ============================================================================
// Module : matmul_proto_pkg
// Brief  : Shared constants, phase/handshake enums and header-byte helper for
//          the matrix-multiplier byte protocol.
// Rev    : 1.0 - initial release
// ============================================================================
package matmul_proto_pkg;

    localparam int         HDR_LEN   = 6;
    localparam logic [2:0] HDR_N_HI  = 3'd0;
    localparam logic [2:0] HDR_N_LO  = 3'd1;
    localparam logic [2:0] HDR_M_HI  = 3'd2;
    localparam logic [2:0] HDR_M_LO  = 3'd3;
    localparam logic [2:0] HDR_SCALE = 3'd4;
    localparam logic [2:0] HDR_SHIFT = 3'd5;

    localparam int N_ROW_CACHED_DEF = 15;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_HDR  = 3'd1,
        PH_ROWS = 3'd2,
        PH_COL  = 3'd3,
        PH_RES  = 3'd4
    } phase_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_BUSY = 2'd2,
        TX_GAP  = 2'd3
    } tx_state_t;

    function automatic logic [7:0] hdr_byte(
        input logic [2:0]  idx,
        input logic [11:0] n,
        input logic [11:0] m,
        input logic [7:0]  scale,
        input logic [7:0]  shift
    );
        logic [7:0] b;
        case (idx)
            HDR_N_HI:  b = {4'h0, n[11:8]};
            HDR_N_LO:  b = n[7:0];
            HDR_M_HI:  b = {4'h0, m[11:8]};
            HDR_M_LO:  b = m[7:0];
            HDR_SCALE: b = scale;
            HDR_SHIFT: b = shift;
            default:   b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx_hs.sv
`default_nettype none
// ============================================================================
// Module : uart_byte_tx_hs
// Brief  : Per-byte we/wait transmit handshake; ack pulses once the byte has
//          been accepted and uart_we has dropped.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_byte_tx_hs
    import matmul_proto_pkg::*;
(
    input  logic       clk_48mhz,
    input  logic       resetn,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       ready,
    output logic       ack,
    output logic [7:0] uart_di,
    output logic       uart_we,
    input  logic       uart_wait
);

    tx_state_t  r_state;
    tx_state_t  w_state_next;
    logic [7:0] r_di;
    logic       r_we;

    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        ack          = 1'b0;
        case (r_state)
            TX_IDLE: begin
                ready = 1'b1;
                if (load) w_state_next = TX_REQ;
            end
            TX_REQ:  if (uart_wait)  w_state_next = TX_BUSY;
            TX_BUSY: if (!uart_wait) w_state_next = TX_GAP;
            TX_GAP: begin
                // uart_we is already low here, guaranteeing the idle gap
                ack          = 1'b1;
                w_state_next = TX_IDLE;
            end
            default: w_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            r_di <= 8'h00;
            r_we <= 1'b0;
        end else if (r_state == TX_IDLE && load) begin
            r_di <= load_data;
            r_we <= 1'b1;
        end else if (r_state == TX_BUSY && !uart_wait) begin
            r_we <= 1'b0;
        end
    end

    assign uart_di = r_di;
    assign uart_we = r_we;

endmodule
`default_nettype wire

// File: rtl/matmul_job_sender.sv
`default_nettype none
// ============================================================================
// Module : matmul_job_sender
// Brief  : Serializes a matmul job (header, cached rows, columns) onto a byte
//          UART and returns the far end's results tagged with row/column.
// Rev    : 1.0 - initial release
// ============================================================================
module matmul_job_sender
    import matmul_proto_pkg::*;
#(
    parameter int          N_ROW_CACHED = N_ROW_CACHED_DEF,
    parameter logic [23:0] RX_TIMEOUT   = 24'd4800000
) (
    input  logic        clk_48mhz,
    input  logic        resetn,
    input  logic        start,
    input  logic [11:0] cfg_n,
    input  logic [11:0] cfg_m,
    input  logic [7:0]  cfg_scale,
    input  logic [7:0]  cfg_shift,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [7:0]  uart_di,
    output logic        uart_we,
    input  logic        uart_wait,
    output logic        uart_re,
    input  logic [7:0]  uart_do,
    input  logic        uart_ready,
    output logic [7:0]  res_data,
    output logic        res_valid,
    output logic [3:0]  res_row,
    output logic [11:0] res_col,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [3:0] c_last_row = 4'(N_ROW_CACHED - 1);

    phase_t      r_state;
    phase_t      w_state_next;
    logic [11:0] r_cfg_n, r_cfg_m;
    logic [7:0]  r_cfg_scale, r_cfg_shift;
    logic [11:0] r_byte_idx, r_col_idx;
    logic [3:0]  r_row_idx, r_res_idx;
    logic        r_tx_pending, r_re, r_rx_hold;
    logic [7:0]  r_res_data;
    logic        r_res_valid, r_done, r_err;
    logic [3:0]  r_res_row;
    logic [11:0] r_res_col;
    logic [23:0] r_tmo_cnt;

    logic        w_tx_ready, w_tx_ack, w_tx_load, w_fetch;
    logic [7:0]  w_tx_data;
    logic        w_byte_last, w_row_last, w_res_last, w_col_last;
    logic        w_rx_take, w_timeout;

    assign w_byte_last = (r_state == PH_HDR) ? (r_byte_idx == 12'(HDR_LEN - 1))
                                             : (r_byte_idx == r_cfg_n);
    assign w_row_last  = (r_row_idx == c_last_row);
    assign w_res_last  = (r_res_idx == c_last_row);
    assign w_col_last  = (r_col_idx == r_cfg_m);
    assign w_rx_take   = (r_state == PH_RES) && r_re && uart_ready;
    assign w_timeout   = (r_state == PH_RES) && !uart_ready
                         && (r_tmo_cnt == RX_TIMEOUT - 24'd1);

    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            r_state <= PH_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tx_load    = 1'b0;
        w_fetch      = 1'b0;
        w_tx_data    = src_data;
        case (r_state)
            PH_IDLE: if (start) w_state_next = PH_HDR;
            PH_HDR: begin
                w_tx_data = hdr_byte(r_byte_idx[2:0], r_cfg_n, r_cfg_m,
                                     r_cfg_scale, r_cfg_shift);
                w_tx_load = w_tx_ready && !r_tx_pending;
                if (w_tx_ack && w_byte_last) w_state_next = PH_ROWS;
            end
            PH_ROWS, PH_COL: begin
                w_fetch   = w_tx_ready && !r_tx_pending && src_valid;
                w_tx_load = w_fetch;
                if (w_tx_ack && w_byte_last) begin
                    if (r_state == PH_COL)  w_state_next = PH_RES;
                    else if (w_row_last)    w_state_next = PH_COL;
                end
            end
            PH_RES: begin
                if (w_timeout)                    w_state_next = PH_IDLE;
                else if (r_rx_hold && w_res_last) w_state_next = w_col_last ? PH_IDLE : PH_COL;
            end
            default: w_state_next = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            r_cfg_n      <= '0;
            r_cfg_m      <= '0;
            r_cfg_scale  <= '0;
            r_cfg_shift  <= '0;
            r_byte_idx   <= '0;
            r_col_idx    <= '0;
            r_row_idx    <= '0;
            r_res_idx    <= '0;
            r_tx_pending <= 1'b0;
            r_re         <= 1'b0;
            r_rx_hold    <= 1'b0;
            r_res_data   <= '0;
            r_res_valid  <= 1'b0;
            r_res_row    <= '0;
            r_res_col    <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_tmo_cnt    <= '0;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_res_valid <= 1'b0;

            if (r_state == PH_IDLE && start) begin
                r_cfg_n     <= cfg_n;
                r_cfg_m     <= cfg_m;
                r_cfg_scale <= cfg_scale;
                r_cfg_shift <= cfg_shift;
                r_byte_idx  <= '0;
                r_row_idx   <= '0;
                r_col_idx   <= '0;
                r_res_idx   <= '0;
            end

            if (w_tx_load)     r_tx_pending <= 1'b1;
            else if (w_tx_ack) r_tx_pending <= 1'b0;

            // Byte/row counters advance only once a byte has fully left
            if (w_tx_ack) begin
                if (!w_byte_last) begin
                    r_byte_idx <= r_byte_idx + 12'd1;
                end else begin
                    r_byte_idx <= '0;
                    if (r_state == PH_ROWS) r_row_idx <= w_row_last ? 4'd0 : r_row_idx + 4'd1;
                    if (r_state == PH_COL) begin
                        r_re      <= 1'b1;
                        r_res_idx <= '0;
                    end
                end
            end

            if (w_rx_take) begin
                r_re       <= 1'b0;
                r_res_data <= uart_do;
                r_rx_hold  <= 1'b1;
            end

            if (r_rx_hold) begin
                r_rx_hold   <= 1'b0;
                r_res_valid <= 1'b1;
                r_res_row   <= r_res_idx;
                r_res_col   <= r_col_idx;
                if (!w_res_last) begin
                    r_res_idx <= r_res_idx + 4'd1;
                    r_re      <= 1'b1;
                end else begin
                    r_res_idx <= '0;
                    if (w_col_last) begin
                        r_done    <= 1'b1;
                        r_col_idx <= '0;
                    end else begin
                        r_col_idx <= r_col_idx + 12'd1;
                    end
                end
            end

            if (r_state != PH_RES || uart_ready) r_tmo_cnt <= '0;
            else                                 r_tmo_cnt <= r_tmo_cnt + 24'd1;

            if (w_timeout) begin
                r_err        <= 1'b1;
                r_re         <= 1'b0;
                r_rx_hold    <= 1'b0;
                r_tx_pending <= 1'b0;
            end
        end
    end

    uart_byte_tx_hs u_tx (
        .clk_48mhz (clk_48mhz),
        .resetn    (resetn),
        .load      (w_tx_load),
        .load_data (w_tx_data),
        .ready     (w_tx_ready),
        .ack       (w_tx_ack),
        .uart_di   (uart_di),
        .uart_we   (uart_we),
        .uart_wait (uart_wait)
    );

    assign src_ready = w_fetch;
    assign uart_re   = r_re;
    assign res_data  = r_res_data;
    assign res_valid = r_res_valid;
    assign res_row   = r_res_row;
    assign res_col   = r_res_col;
    assign busy      = (r_state != PH_IDLE);
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_matmul_job_sender.sv
`default_nettype none
// ============================================================================
// Module : tb_matmul_job_sender
// Brief  : Scoreboard bench: UART far-end model, payload source, result monitor.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_matmul_job_sender;

    localparam int NR = 15;

    logic        clk_48mhz = 1'b0;
    logic        resetn, start;
    logic [11:0] cfg_n, cfg_m;
    logic [7:0]  cfg_scale, cfg_shift;
    logic [7:0]  src_data;
    logic        src_valid, src_ready;
    logic [7:0]  uart_di;
    logic        uart_we, uart_wait, uart_re;
    logic [7:0]  uart_do;
    logic        uart_ready;
    logic [7:0]  res_data;
    logic        res_valid;
    logic [3:0]  res_row;
    logic [11:0] res_col;
    logic        busy, done, err;

    always #10 clk_48mhz = ~clk_48mhz;

    matmul_job_sender #(.N_ROW_CACHED(NR), .RX_TIMEOUT(24'd1000)) dut (
        .clk_48mhz(clk_48mhz), .resetn(resetn), .start(start),
        .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .uart_di(uart_di), .uart_we(uart_we), .uart_wait(uart_wait),
        .uart_re(uart_re), .uart_do(uart_do), .uart_ready(uart_ready),
        .res_data(res_data), .res_valid(res_valid), .res_row(res_row), .res_col(res_col),
        .busy(busy), .done(done), .err(err)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    logic [7:0]  tx_exp[$];
    logic [7:0]  src_q[$];
    logic [7:0]  rx_q[$];
    logic [23:0] res_exp[$];
    int we_rises = 0, res_cnt = 0, done_cnt = 0, err_cnt = 0, src_pulses = 0;
    int rdy_cyc = 0, err_cyc = 0;
    int job_n = 0, job_k = 0, job_res0 = 0;
    bit stall = 1'b0;

    always @(posedge clk_48mhz) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Far-end transmit side: acknowledges each byte and scores it
    initial begin : tx_model
        logic [7:0] b;
        int rows_end, c;
        uart_wait = 1'b0;
        forever begin
            @(posedge clk_48mhz); #1;
            if (resetn && uart_we) begin
                b = uart_di;
                we_rises++;
                if (tx_exp.size() == 0) check("tx_unexpected", b, 'hFFFF);
                else check("tx_byte", b, tx_exp.pop_front());
                rows_end = 6 + NR * (job_n + 1);
                if (job_k >= rows_end && ((job_k - rows_end) % (job_n + 1)) == 0) begin
                    c = (job_k - rows_end) / (job_n + 1);
                    if (c > 0) check("col_order", (res_cnt - job_res0) >= c * NR, 1);
                end
                job_k++;
                uart_wait = 1'b1;
                for (int i = 0; i < 2 && resetn; i++) begin @(posedge clk_48mhz); #1; end
                if (resetn) check("di_stable", uart_di, b);
                uart_wait = 1'b0;
                for (int g = 0; g < 20 && resetn && uart_we; g++) begin @(posedge clk_48mhz); #1; end
                if (resetn) check("we_release", uart_we, 0);
            end
        end
    end

    // Far-end receive side: returns queued result bytes when asked
    initial begin : rx_model
        uart_ready = 1'b0;
        uart_do    = 8'h00;
        forever begin
            @(posedge clk_48mhz); #1;
            if (resetn && uart_re && rx_q.size() > 0) begin
                repeat (2) @(posedge clk_48mhz);
                #1;
                if (resetn && uart_re && rx_q.size() > 0) begin
                    uart_do    = rx_q.pop_front();
                    uart_ready = 1'b1;
                    @(posedge clk_48mhz); #1;
                    uart_ready = 1'b0;
                    rdy_cyc    = cyc;
                end
            end
        end
    end

    initial begin : src_driver
        bit took;
        src_valid = 1'b0;
        src_data  = 8'h00;
        forever begin
            @(negedge clk_48mhz);
            took = src_ready && src_valid;
            @(posedge clk_48mhz); #1;
            if (took) begin
                src_pulses++;
                if (src_q.size() > 0) void'(src_q.pop_front());
            end
            src_valid = !stall && (src_q.size() > 0);
            src_data  = src_valid ? src_q[0] : 8'h00;
        end
    end

    always @(negedge clk_48mhz) begin
        if (res_valid === 1'b1) begin
            if (res_exp.size() == 0) check("res_unexpected", {res_data, res_row, res_col}, 'hFFFFFFFF);
            else check("result", {res_data, res_row, res_col}, res_exp.pop_front());
            res_cnt++;
        end
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic start_job(input logic [11:0] n, input logic [11:0] m,
                             input logic [7:0] scale, input logic [7:0] shift,
                             input bit payload, input logic [7:0] src_base,
                             input logic [7:0] resp_base, input int n_resp);
        logic [7:0] s, rv;
        int k;
        s  = src_base;
        rv = resp_base;
        k  = 0;
        tx_exp.push_back({4'h0, n[11:8]});
        tx_exp.push_back(n[7:0]);
        tx_exp.push_back({4'h0, m[11:8]});
        tx_exp.push_back(m[7:0]);
        tx_exp.push_back(scale);
        tx_exp.push_back(shift);
        if (payload) begin
            for (int i = 0; i < (NR + int'(m) + 1) * (int'(n) + 1); i++) begin
                src_q.push_back(s);
                tx_exp.push_back(s);
                s++;
            end
        end
        for (int c = 0; c <= int'(m); c++)
            for (int r = 0; r < NR; r++)
                if (k < n_resp) begin
                    rx_q.push_back(rv);
                    res_exp.push_back({rv, 4'(r), 12'(c)});
                    rv++;
                    k++;
                end
        job_n    = int'(n);
        job_k    = 0;
        job_res0 = res_cnt;
        @(negedge clk_48mhz);
        cfg_n = n; cfg_m = m; cfg_scale = scale; cfg_shift = shift;
        start = 1'b1;
        @(negedge clk_48mhz);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0, e0, i;
        d0 = done_cnt; e0 = err_cnt; i = 0;
        while (done_cnt == d0 && err_cnt == e0 && i < budget) begin
            @(negedge clk_48mhz);
            i++;
        end
        repeat (3) @(negedge clk_48mhz);
        check("done_pulse", done_cnt - d0, 1);
        check("no_err", err_cnt - e0, 0);
        check("tx_left", tx_exp.size(), 0);
        check("res_left", res_exp.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk_48mhz);
        #3 resetn = 1'b0;
        #1 check("async_reset_out",
                 {uart_we, uart_re, src_ready, busy, done, err, res_valid, uart_di, res_data, res_row, res_col}, 0);
        tx_exp.delete(); src_q.delete(); rx_q.delete(); res_exp.delete();
        repeat (3) @(negedge clk_48mhz);
        resetn = 1'b1;
        repeat (2) @(negedge clk_48mhz);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w0, r0, e0, i, p0, we_hi, lat;
        resetn = 1'b0; start = 1'b0;
        cfg_n = '0; cfg_m = '0; cfg_scale = '0; cfg_shift = '0;
        repeat (3) @(negedge clk_48mhz);
        check("reset_state",
              {uart_we, uart_re, src_ready, busy, done, err, res_valid, uart_di, res_data, res_row, res_col}, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk_48mhz);

        // Basic job: n=1, m=0
        w0 = we_rises; r0 = res_cnt;
        start_job(12'd1, 12'd0, 8'h01, 8'h00, 1'b1, 8'h10, 8'h80, 15);
        wait_done(5000);
        check("basic_we_count", we_rises - w0, 38);
        check("basic_res_count", res_cnt - r0, 15);

        // Header encoding for wide cfg values; source left empty so it stalls in ROWS
        w0 = we_rises;
        start_job(12'h123, 12'h456, 8'hA5, 8'h07, 1'b0, 8'h00, 8'h00, 0);
        i = 0;
        while (tx_exp.size() != 0 && i < 500) begin @(negedge clk_48mhz); i++; end
        repeat (20) @(negedge clk_48mhz);
        check("hdr_sent", tx_exp.size(), 0);
        check("hdr_we_count", we_rises - w0, 6);
        check("hdr_busy", busy, 1);
        do_reset();

        // Three columns, one byte per row
        w0 = we_rises; r0 = res_cnt;
        start_job(12'd0, 12'd2, 8'hFE, 8'h03, 1'b1, 8'h20, 8'h60, 45);
        wait_done(5000);
        check("m2_we_count", we_rises - w0, 24);
        check("m2_res_count", res_cnt - r0, 45);

        // Source stall mid-ROWS
        w0 = we_rises; p0 = src_pulses;
        start_job(12'd1, 12'd0, 8'h11, 8'h22, 1'b1, 8'h40, 8'h90, 15);
        i = 0;
        while (src_pulses - p0 < 10 && i < 1000) begin @(negedge clk_48mhz); i++; end
        check("stall_reached", src_pulses - p0 >= 10, 1);
        stall = 1'b1;
        repeat (20) @(negedge clk_48mhz);
        p0 = src_pulses; we_hi = 0;
        repeat (180) begin
            @(negedge clk_48mhz);
            if (uart_we) we_hi++;
        end
        check("stall_we_low", we_hi, 0);
        check("stall_no_src_ready", src_pulses - p0, 0);
        stall = 1'b0;
        wait_done(5000);
        check("stall_we_count", we_rises - w0, 38);

        // Receive timeout after three results
        r0 = res_cnt; e0 = err_cnt;
        start_job(12'd0, 12'd0, 8'h01, 8'h01, 1'b1, 8'h50, 8'hA0, 3);
        i = 0;
        while (err_cnt == e0 && i < 5000) begin @(negedge clk_48mhz); i++; end
        lat = err_cyc - rdy_cyc;
        check("tmo_err_pulse", err_cnt - e0, 1);
        if (lat < 999 || lat > 1001) check("tmo_latency", lat, 1000);
        else check("tmo_latency", 1, 1 + 0 * lat);
        @(negedge clk_48mhz);
        check("tmo_idle", {busy, uart_re, uart_we}, 0);
        check("tmo_res_count", res_cnt - r0, 3);
        w0 = we_rises;
        start_job(12'd0, 12'd1, 8'h33, 8'h44, 1'b1, 8'h60, 8'hB0, 30);
        wait_done(5000);
        check("post_tmo_we_count", we_rises - w0, 23);

        // Async reset while a column byte is in flight
        start_job(12'd1, 12'd1, 8'h55, 8'h66, 1'b1, 8'h70, 8'hC0, 30);
        i = 0;
        while (!(job_k >= 37 && uart_we === 1'b1) && i < 2000) begin @(negedge clk_48mhz); i++; end
        check("col_reached", job_k >= 37 && uart_we === 1'b1, 1);
        do_reset();
        w0 = we_rises; r0 = res_cnt;
        start_job(12'd1, 12'd0, 8'h77, 8'h88, 1'b1, 8'h80, 8'hD0, 15);
        repeat (60) @(negedge clk_48mhz);
        start = 1'b1;
        @(negedge clk_48mhz);
        start = 1'b0;
        wait_done(5000);
        check("recover_we_count", we_rises - w0, 38);
        check("recover_res_count", res_cnt - r0, 15);
        repeat (5) @(negedge clk_48mhz);
        check("recover_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
